// File: rtl/fp_pkg.sv
// Shared definitions for the fixed-point BCD entry path: digit count,
// command encodings and entry state enum.
package fp_pkg;

  localparam int unsigned NDIG  = 12;
  localparam int unsigned BCD_W = 4 * NDIG;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] CMD_DIGIT     = 2'b00;
  localparam logic [1:0] CMD_ENTER     = 2'b01;
  localparam logic [1:0] CMD_CLEAR     = 2'b10;
  localparam logic [1:0] CMD_BACKSPACE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ENTRY = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/fp_bcd_entry.sv
// Digit-entry front end: assembles up to NDIG BCD digits, MSD first, into a
// packed fraction and presents it to fp_bcd2bin on ENTER.
// Optional macro FP_ENTRY_BACKSPACE_EN enables digit removal on BACKSPACE;
// without it BACKSPACE is rejected with an err pulse.
module fp_bcd_entry
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cmd,
  input  logic [3:0]       in_digit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BCD_W-1:0] fp_bcd,
  output logic [CNT_W-1:0] digit_cnt,
  output logic             err
);

  state_t state;

  // Commands are only taken while not presenting a result.
  assign in_ready = (state != ST_HOLD);

  // Entry state, digit register and registered outputs in one process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      fp_bcd    <= '0;
      digit_cnt <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE, ST_ENTRY: begin
          if (in_valid) begin
            case (in_cmd)
              CMD_DIGIT: begin
                if ((digit_cnt < CNT_W'(NDIG)) && (in_digit <= 4'd9)) begin
                  for (int unsigned i = 0; i < NDIG; i++) begin
                    if (digit_cnt == CNT_W'(i)) begin
                      fp_bcd[4*(NDIG-i)-1 -: 4] <= in_digit;
                    end
                  end
                  digit_cnt <= digit_cnt + CNT_W'(1);
                  state     <= ST_ENTRY;
                end else begin
                  err <= 1'b1;
                end
              end
              CMD_ENTER: begin
                state     <= ST_HOLD;
                out_valid <= 1'b1;
              end
              CMD_CLEAR: begin
                fp_bcd    <= '0;
                digit_cnt <= '0;
                state     <= ST_IDLE;
              end
              default: begin
`ifdef FP_ENTRY_BACKSPACE_EN
                if (digit_cnt != '0) begin
                  for (int unsigned i = 0; i < NDIG; i++) begin
                    if (digit_cnt == CNT_W'(i + 1)) begin
                      fp_bcd[4*(NDIG-i)-1 -: 4] <= 4'd0;
                    end
                  end
                  digit_cnt <= digit_cnt - CNT_W'(1);
                  state     <= (digit_cnt == CNT_W'(1)) ? ST_IDLE : ST_ENTRY;
                end else begin
                  err <= 1'b1;
                end
`else
                err <= 1'b1;
`endif
              end
            endcase
          end
        end
        ST_HOLD: begin
          // Result is consumed on the output handshake; start a fresh entry.
          if (out_ready) begin
            fp_bcd    <= '0;
            digit_cnt <= '0;
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_bcd_entry.sv
// Bench for fp_bcd_entry: directed scenarios plus randomized commands,
// checked every cycle against a digit-queue reference model.
module tb_fp_bcd_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_cmd = 2'b00;
  logic [3:0]  in_digit = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [47:0] fp_bcd;
  logic [3:0]  digit_cnt;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: entered digits, result-held flag, expected err pulse.
  int q[$];
  bit m_hold = 1'b0;
  bit m_err  = 1'b0;

  fp_bcd_entry dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cmd    (in_cmd),
    .in_digit  (in_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_bcd    (fp_bcd),
    .digit_cnt (digit_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [47:0] model_value();
    logic [47:0] v = '0;
    for (int i = 0; i < q.size(); i++) begin
      v = v | (48'(q[i]) << (4 * (11 - i)));
    end
    return v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".fp_bcd"},    fp_bcd,            model_value());
    check({tag, ".cnt"},       48'(digit_cnt),    48'(q.size()));
    check({tag, ".out_valid"}, 48'(out_valid),    48'(m_hold));
    check({tag, ".in_ready"},  48'(in_ready),     48'(!m_hold));
    check({tag, ".err"},       48'(err),          48'(m_err));
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input string tag, input bit v, input logic [1:0] c,
                      input int d, input bit ordy);
    in_valid  = v;
    in_cmd    = c;
    in_digit  = 4'(d);
    out_ready = ordy;
    m_err = 1'b0;
    if (m_hold) begin
      if (ordy) begin
        q.delete();
        m_hold = 1'b0;
      end
    end else if (v) begin
      case (c)
        2'b00: if (q.size() < 12 && d <= 9) q.push_back(d); else m_err = 1'b1;
        2'b01: m_hold = 1'b1;
        2'b10: q.delete();
        default: begin
`ifdef FP_ENTRY_BACKSPACE_EN
          if (q.size() > 0) void'(q.pop_back()); else m_err = 1'b1;
`else
          m_err = 1'b1;
`endif
        end
      endcase
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_cycle();
    step("idle", 1'b0, 2'b00, 0, 1'b0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    idle_cycle();

    // Digits 1,2,5 then ENTER, held one cycle, then consumed
    step("d1", 1'b1, 2'b00, 1, 1'b0);
    step("d2", 1'b1, 2'b00, 2, 1'b0);
    step("d5", 1'b1, 2'b00, 5, 1'b0);
    step("enter", 1'b1, 2'b01, 0, 1'b1);
    check("plan1.value", fp_bcd, 48'h125000000000);
    step("consume", 1'b0, 2'b00, 0, 1'b1);
    check("plan1.cleared", fp_bcd, 48'h0);

    // Full register then overflow digit
    for (int i = 0; i < 12; i++) step("nine", 1'b1, 2'b00, 9, 1'b0);
    step("overflow", 1'b1, 2'b00, 3, 1'b0);
    check("plan2.err", 48'(err), 48'h1);
    check("plan2.value", fp_bcd, 48'h999999999999);
    step("enter_full", 1'b1, 2'b01, 0, 1'b0);
    step("consume_full", 1'b0, 2'b00, 0, 1'b1);

    // Invalid digit in IDLE, then ENTER of empty entry
    step("digit_a", 1'b1, 2'b00, 10, 1'b0);
    check("plan3.err", 48'(err), 48'h1);
    step("enter_empty", 1'b1, 2'b01, 0, 1'b0);
    check("plan3.zero", fp_bcd, 48'h0);

    // HOLD with back-pressure while digits are offered
    for (int i = 0; i < 5; i++) step("hold_bp", 1'b1, 2'b00, 4, 1'b0);
    step("hold_release", 1'b1, 2'b00, 4, 1'b1);

    // BACKSPACE behaviour
    step("d7", 1'b1, 2'b00, 7, 1'b0);
    step("d8", 1'b1, 2'b00, 8, 1'b0);
    step("bs1", 1'b1, 2'b11, 0, 1'b0);
`ifdef FP_ENTRY_BACKSPACE_EN
    check("plan5.bs1", fp_bcd, 48'h700000000000);
    step("bs2", 1'b1, 2'b11, 0, 1'b0);
    step("bs3", 1'b1, 2'b11, 0, 1'b0);
    check("plan5.bs_err", 48'(err), 48'h1);
`else
    check("plan5.bs_rej", fp_bcd, 48'h780000000000);
`endif
    step("clear", 1'b1, 2'b10, 0, 1'b0);
    step("clear_empty", 1'b1, 2'b10, 0, 1'b0);

    // Randomized command stream
    for (int n = 0; n < 3000; n++) begin
      int r;
      int c;
      r = int'($urandom_range(0, 99));
      if (r < 60)      c = 0;
      else if (r < 70) c = 1;
      else if (r < 78) c = 2;
      else             c = 3;
      step("rand", ($urandom_range(0, 9) < 8), 2'(c),
           int'($urandom_range(0, 11)), ($urandom_range(0, 1) == 1));
    end

    // Asynchronous reset between clock edges mid-entry
    step("pre_clr", 1'b1, 2'b10, 0, 1'b1);
    step("pre_clr2", 1'b0, 2'b00, 0, 1'b1);
    for (int i = 0; i < 5; i++) step("five", 1'b1, 2'b00, i + 1, 1'b0);
    check("async.cnt_before", 48'(digit_cnt), 48'd5);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_hold = 1'b0;
    m_err  = 1'b0;
    check_all("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycle();
    step("post_d", 1'b1, 2'b00, 6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
